// File: rtl/clock_gate_controller_if.sv
// Handshake bundle between stall requesters and the clock gate controller.
// master = requester/observer side, slave = controller side.
interface clock_gate_controller_if #(
  parameter int NUM_REQ     = 4,
  parameter int COUNT_WIDTH = 32
);
  logic [NUM_REQ-1:0]     stall_req;
  logic                   count_clear;
  logic                   ce_n;
  logic                   stall_ack;
  logic [1:0]             state;
  logic [COUNT_WIDTH-1:0] gated_count;

  modport master (
    output stall_req, count_clear,
    input  ce_n, stall_ack, state, gated_count
  );

  modport slave (
    input  stall_req, count_clear,
    output ce_n, stall_ack, state, gated_count
  );
endinterface

// File: rtl/clock_gate_controller.sv
// Stall-driven clock gate controller: RUN/DRAIN/GATED/WAKE FSM driving a clock buffer CE pin.
// Optional gated-cycle counter is built only when CLOCK_GATE_COUNTER_EN is defined.
module clock_gate_controller #(
  parameter int NUM_REQ      = 4,
  parameter int DRAIN_CYCLES = 2,
  parameter int WAKE_CYCLES  = 1,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  clock_gate_controller_if.slave   bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    GATED = 2'd2,
    WAKE  = 2'd3
  } state_t;

  // The load value counts the cycle spent on the entry edge, so a phase lasting
  // N cycles loads N-1 and exits on the edge that sees zero.
  localparam logic [7:0] DRAIN_LOAD = (DRAIN_CYCLES > 0) ? 8'(DRAIN_CYCLES - 1) : 8'd0;
  localparam logic [7:0] WAKE_LOAD  = (WAKE_CYCLES  > 0) ? 8'(WAKE_CYCLES  - 1) : 8'd0;

  logic [NUM_REQ-1:0] req;
  logic               any_req;
  logic [1:0]         rst_sync;
  logic               run_ok;
  state_t             st;
  logic [7:0]         cnt;
  logic               ce_n_q;
  logic               ack_q;

  assign req     = bus.stall_req;
  assign any_req = |req;
  assign run_ok  = rst_sync[1];

  // Reset assertion is immediate; release is held off two edges before gating may start.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st     <= RUN;
      cnt    <= 8'd0;
      ce_n_q <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      case (st)
        RUN: begin
          if (any_req && run_ok) begin
            if (DRAIN_CYCLES == 0) begin
              st     <= GATED;
              ce_n_q <= 1'b1;
              ack_q  <= 1'b1;
            end else begin
              st  <= DRAIN;
              cnt <= DRAIN_LOAD;
            end
          end
        end
        DRAIN: begin
          if (!any_req) begin
            st <= RUN;
          end else if (cnt == 8'd0) begin
            st     <= GATED;
            ce_n_q <= 1'b1;
            ack_q  <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        GATED: begin
          if (!any_req) begin
            ce_n_q <= 1'b0;
            if (WAKE_CYCLES == 0) begin
              st    <= RUN;
              ack_q <= 1'b0;
            end else begin
              st  <= WAKE;
              cnt <= WAKE_LOAD;
            end
          end
        end
        WAKE: begin
          // New requests cannot cut the wake settle short; they are honoured at its end.
          if (cnt == 8'd0) begin
            if (any_req && DRAIN_CYCLES == 0) begin
              st     <= GATED;
              ce_n_q <= 1'b1;
            end else if (any_req) begin
              st    <= DRAIN;
              cnt   <= DRAIN_LOAD;
              ack_q <= 1'b0;
            end else begin
              st    <= RUN;
              ack_q <= 1'b0;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          st     <= RUN;
          ce_n_q <= 1'b0;
          ack_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ce_n      = ce_n_q;
  assign bus.stall_ack = ack_q;
  assign bus.state     = st;

`ifdef CLOCK_GATE_COUNTER_EN
  logic [COUNT_WIDTH-1:0] gated_cnt;

  // Saturating count of GATED cycles; clear takes priority over increment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gated_cnt <= '0;
    end else if (bus.count_clear) begin
      gated_cnt <= '0;
    end else if (st == GATED && gated_cnt != '1) begin
      gated_cnt <= gated_cnt + COUNT_WIDTH'(1);
    end
  end

  assign bus.gated_count = gated_cnt;
`else
  logic unused_count_clear;

  assign unused_count_clear = bus.count_clear;
  assign bus.gated_count    = '0;
`endif

endmodule
